serial_shift_tx: RTL and testbench

SERIAL_SHIFT_TX -- requirements
Module: serial_shift_tx

---
 rtl/serial_shift_tx.sv | 164 ++++++++++++++++
 tb/tb_serial_shift_tx.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/serial_shift_tx.sv
// Serial frame transmitter: START(0), WIDTH data bits LSB first, optional even parity, STOP(1).
// The optional parity bit is compiled in by defining SERIAL_SHIFT_TX_PARITY_EN.
module serial_shift_tx #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned BIT_CYCLES = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] DATA_IN,
  input  logic             LOAD_VALID,
  output logic             LOAD_READY,
  output logic             SER_OUT,
  output logic             BUSY,
  output logic             DONE
);

  localparam int unsigned          BitCntW   = $clog2(WIDTH) + 1;
  localparam logic [7:0]           CycReload = 8'(BIT_CYCLES - 1);
  localparam logic [BitCntW-1:0]   LastBit   = BitCntW'(WIDTH - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   shift_q, shift_d;
  logic [BitCntW-1:0] bit_cnt_q, bit_cnt_d;
  logic [7:0]         cyc_cnt_q, cyc_cnt_d;
  logic               ser_out_q, ser_out_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               ready_q, ready_d;

`ifdef SERIAL_SHIFT_TX_PARITY_EN
  logic parity_q, parity_d;
`endif

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    cyc_cnt_d = cyc_cnt_q;
    ser_out_d = ser_out_q;
`ifdef SERIAL_SHIFT_TX_PARITY_EN
    parity_d  = parity_q;
`endif

    unique case (state_q)
      StIdle: begin
        ser_out_d = 1'b1;
        if (LOAD_VALID) begin
          state_d   = StStart;
          shift_d   = DATA_IN;
          cyc_cnt_d = CycReload;
          ser_out_d = 1'b0;
`ifdef SERIAL_SHIFT_TX_PARITY_EN
          parity_d  = ^DATA_IN;
`endif
        end
      end
      StStart: begin
        if (cyc_cnt_q == 8'd0) begin
          state_d   = StData;
          cyc_cnt_d = CycReload;
          bit_cnt_d = '0;
          ser_out_d = shift_q[0];
        end else begin
          cyc_cnt_d = cyc_cnt_q - 8'd1;
        end
      end
      StData: begin
        if (cyc_cnt_q == 8'd0) begin
          cyc_cnt_d = CycReload;
          if (bit_cnt_q == LastBit) begin
`ifdef SERIAL_SHIFT_TX_PARITY_EN
            state_d   = StParity;
            ser_out_d = parity_q;
`else
            state_d   = StStop;
            ser_out_d = 1'b1;
`endif
          end else begin
            // Bit 0 of the shift register always holds the bit on the line.
            bit_cnt_d = bit_cnt_q + 1'b1;
            shift_d   = shift_q >> 1;
            ser_out_d = shift_q[1];
          end
        end else begin
          cyc_cnt_d = cyc_cnt_q - 8'd1;
        end
      end
`ifdef SERIAL_SHIFT_TX_PARITY_EN
      StParity: begin
        if (cyc_cnt_q == 8'd0) begin
          state_d   = StStop;
          cyc_cnt_d = CycReload;
          ser_out_d = 1'b1;
        end else begin
          cyc_cnt_d = cyc_cnt_q - 8'd1;
        end
      end
`endif
      StStop: begin
        ser_out_d = 1'b1;
        if (cyc_cnt_q == 8'd0) begin
          state_d = StIdle;
        end else begin
          cyc_cnt_d = cyc_cnt_q - 8'd1;
        end
      end
      default: begin
        state_d   = StIdle;
        ser_out_d = 1'b1;
      end
    endcase

    // Status flags describe the cycle about to start, so they are registered with the state.
    busy_d  = (state_d != StIdle);
    ready_d = (state_d == StIdle);
    done_d  = (state_d == StStop) && (cyc_cnt_d == 8'd0);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= StIdle;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      cyc_cnt_q <= '0;
      ser_out_q <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      cyc_cnt_q <= cyc_cnt_d;
      ser_out_q <= ser_out_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ready_q   <= ready_d;
    end
  end

`ifdef SERIAL_SHIFT_TX_PARITY_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end
`endif

  assign LOAD_READY = ready_q;
  assign SER_OUT    = ser_out_q;
  assign BUSY       = busy_q;
  assign DONE       = done_q;

endmodule

// File: tb/tb_serial_shift_tx.sv
// Bench for serial_shift_tx: one instance with BIT_CYCLES=1 and one with BIT_CYCLES=3,
// each checked cycle by cycle against a frame built from the word as a list of line levels.
module tb_serial_shift_tx;

  localparam int W = 8;
`ifdef SERIAL_SHIFT_TX_PARITY_EN
  localparam int Par = 1;
`else
  localparam int Par = 0;
`endif

  logic         clk = 1'b0;
  logic         rst  [2];
  logic         lv   [2];
  logic [W-1:0] din  [2];
  logic         ser  [2];
  logic         busy [2];
  logic         done [2];
  logic         rdy  [2];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  serial_shift_tx #(.WIDTH(W), .BIT_CYCLES(1)) u_dut_bc1 (
    .CLK       (clk),
    .RST       (rst[0]),
    .DATA_IN   (din[0]),
    .LOAD_VALID(lv[0]),
    .LOAD_READY(rdy[0]),
    .SER_OUT   (ser[0]),
    .BUSY      (busy[0]),
    .DONE      (done[0])
  );

  serial_shift_tx #(.WIDTH(W), .BIT_CYCLES(3)) u_dut_bc3 (
    .CLK       (clk),
    .RST       (rst[1]),
    .DATA_IN   (din[1]),
    .LOAD_VALID(lv[1]),
    .LOAD_READY(rdy[1]),
    .SER_OUT   (ser[1]),
    .BUSY      (busy[1]),
    .DONE      (done[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_idle(input int k, input string tag);
    check($sformatf("%s_ser[%0d]", tag, k), 32'(ser[k]), 32'd1);
    check($sformatf("%s_busy[%0d]", tag, k), 32'(busy[k]), 32'd0);
    check($sformatf("%s_ready[%0d]", tag, k), 32'(rdy[k]), 32'd1);
    check($sformatf("%s_done[%0d]", tag, k), 32'(done[k]), 32'd0);
  endtask

  function automatic int frame_len(input int k);
    return (W + 2 + Par) * ((k == 0) ? 1 : 3);
  endfunction

  // Called at a negedge with the DUT idle. Offers the word, then checks every frame cycle.
  // hold: keep LOAD_VALID high and present next_word for a back-to-back frame.
  // abort_at: frame cycle index after which RST (together with LOAD_VALID) is applied.
  task automatic run_frame(input int k, input logic [W-1:0] word, input bit hold,
                           input logic [W-1:0] next_word, input int abort_at);
    int bc;
    bit exp_q[$];
    bc = (k == 0) ? 1 : 3;
    for (int r = 0; r < bc; r++) exp_q.push_back(1'b0);
    for (int b = 0; b < W; b++)
      for (int r = 0; r < bc; r++) exp_q.push_back(word[b]);
    if (Par != 0)
      for (int r = 0; r < bc; r++) exp_q.push_back(^word);
    for (int r = 0; r < bc; r++) exp_q.push_back(1'b1);

    check($sformatf("ready_before_load[%0d]", k), 32'(rdy[k]), 32'd1);
    din[k] = word;
    lv[k]  = 1'b1;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      check($sformatf("ser[%0d] w=%0h c=%0d", k, word, i), 32'(ser[k]), 32'(exp_q[i]));
      check($sformatf("busy[%0d] c=%0d", k, i), 32'(busy[k]), 32'd1);
      check($sformatf("ready[%0d] c=%0d", k, i), 32'(rdy[k]), 32'd0);
      check($sformatf("done[%0d] c=%0d", k, i), 32'(done[k]),
            32'(i == exp_q.size() - 1));
      if (hold) begin
        if (i == 0) din[k] = next_word;
      end else begin
        // Stray loads and data changes mid-frame must not disturb the word in flight.
        lv[k]  = 1'($urandom_range(0, 1));
        din[k] = W'($urandom);
      end
      if (i == abort_at) begin
        rst[k] = 1'b1;
        lv[k]  = 1'b1;
        @(negedge clk);
        check_idle(k, "after_reset");
        rst[k] = 1'b0;
        lv[k]  = 1'b0;
        return;
      end
    end
    if (!hold) lv[k] = 1'b0;
    @(negedge clk);
    check_idle(k, "after_frame");
  endtask

  initial begin
    logic [W-1:0] w;
    logic [W-1:0] nw;
    bit           hold;
    int           abort_at;

    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1;
      lv[k]  = 1'b0;
      din[k] = '0;
    end
    repeat (2) @(negedge clk);
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check_idle(0, "reset_idle");
      check_idle(1, "reset_idle");
    end

    run_frame(0, 8'hA5, 1'b0, 8'h00, -1);
    run_frame(1, 8'h01, 1'b0, 8'h00, -1);
    run_frame(0, 8'h07, 1'b0, 8'h00, -1);
    run_frame(0, 8'h03, 1'b0, 8'h00, -1);
    run_frame(0, 8'h3C, 1'b0, 8'h00, 4);
    run_frame(0, 8'h55, 1'b1, 8'hAA, -1);
    run_frame(0, 8'hAA, 1'b0, 8'h00, -1);
    run_frame(1, 8'h3C, 1'b0, 8'h00, 10);

    for (int k = 0; k < 2; k++) begin
      w = W'($urandom);
      for (int n = 0; n < 15; n++) begin
        hold     = ($urandom_range(0, 2) == 0);
        nw       = W'($urandom);
        abort_at = -1;
        if ($urandom_range(0, 5) == 0) begin
          abort_at = int'($urandom_range(0, frame_len(k) - 1));
          hold     = 1'b0;
        end
        run_frame(k, w, hold, nw, abort_at);
        if (hold) begin
          w = nw;
        end else begin
          w = W'($urandom);
          repeat ($urandom_range(0, 2)) begin
            @(negedge clk);
            check_idle(k, "gap");
          end
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
